// File: rtl/vgacon_pkg.sv
// Shared constants, FSM encoding and width helpers for the VGA console TTY sequencer.
package vgacon_pkg;

  localparam logic [8:0] BLANK_CELL = 9'h020;

  localparam logic [6:0] CH_BS    = 7'h08;
  localparam logic [6:0] CH_LF    = 7'h0A;
  localparam logic [6:0] CH_CR    = 7'h0D;
  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_TILDE = 7'h7E;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE         = 3'd0;
  localparam state_t ST_WAIT_VBL     = 3'd1;
  localparam state_t ST_SCROLL_COPY  = 3'd2;
  localparam state_t ST_SCROLL_CLEAR = 3'd3;
  localparam state_t ST_CLEAR_ALL    = 3'd4;

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_printable(input logic [6:0] c);
    return (c >= CH_SPACE) && (c <= CH_TILDE);
  endfunction

endpackage

// File: rtl/vgacon_cursor.sv
// Text cursor: row/column counter with advance, newline, carriage return, backspace and home.
module vgacon_cursor
  import vgacon_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 3,
  parameter int unsigned NUM_COLS = 10,
  parameter int unsigned ROW_W    = width_of(NUM_ROWS),
  parameter int unsigned COL_W    = width_of(NUM_COLS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_advance,
  input  logic             i_newline,
  input  logic             i_cr,
  input  logic             i_back,
  input  logic             i_home,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_scroll_needed
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             w_wrap;

  assign w_wrap          = i_newline | (i_advance & (r_col == LAST_COL));
  // Row stays on the last line; the caller scrolls the buffer instead.
  assign o_scroll_needed = w_wrap & (r_row == LAST_ROW);
  assign o_row           = r_row;
  assign o_col           = r_col;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_home) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_wrap) begin
      r_col <= '0;
      if (r_row != LAST_ROW) r_row <= r_row + 1'b1;
    end else if (i_advance) begin
      r_col <= r_col + 1'b1;
    end else if (i_cr) begin
      r_col <= '0;
    end else if (i_back && (r_col != '0)) begin
      r_col <= r_col - 1'b1;
    end
  end

endmodule

// File: rtl/tqvp_vgacon_tty_ctrl.sv
// Terminal sequencer owning the text RAM write port: host cell writes, putc stream, scroll, clear.
// Define VGACON_VBLANK_SYNC_EN to add i_vblank and hold scroll/clear until vertical blank.
module tqvp_vgacon_tty_ctrl
  import vgacon_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 3,
  parameter int unsigned NUM_COLS = 10,
  parameter int unsigned CELL_W   = 9,
  parameter int unsigned ADDR_W   = width_of(NUM_ROWS * NUM_COLS),
  parameter int unsigned ROW_W    = width_of(NUM_ROWS),
  parameter int unsigned COL_W    = width_of(NUM_COLS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_host_wr_valid,
  input  logic [ADDR_W-1:0] i_host_wr_addr,
  input  logic [CELL_W-1:0] i_host_wr_data,
  output logic              o_host_wr_ready,
  input  logic              i_putc_valid,
  input  logic [6:0]        i_putc_data,
  input  logic [1:0]        i_putc_color,
  output logic              o_putc_ready,
  input  logic              i_clr_req,
`ifdef VGACON_VBLANK_SYNC_EN
  input  logic              i_vblank,
`endif
  output logic [ADDR_W-1:0] o_buf_rd_addr,
  input  logic [CELL_W-1:0] i_buf_rd_data,
  output logic              o_buf_we,
  output logic [ADDR_W-1:0] o_buf_waddr,
  output logic [CELL_W-1:0] o_buf_wdata,
  output logic [ROW_W-1:0]  o_cursor_row,
  output logic [COL_W-1:0]  o_cursor_col,
  output logic              o_busy,
  output logic              o_op_done
);

  localparam int unsigned       NUM_CHARS = NUM_ROWS * NUM_COLS;
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(NUM_CHARS - 1);

`ifdef VGACON_VBLANK_SYNC_EN
  localparam logic VBL_GATE = 1'b1;
  logic w_vblank;
  assign w_vblank = i_vblank;
`else
  localparam logic VBL_GATE = 1'b0;
  logic w_vblank;
  assign w_vblank = 1'b1;
`endif

  state_t            r_state, r_target;
  logic [ADDR_W-1:0] r_idx, r_rd_addr, r_waddr;
  logic [CELL_W-1:0] r_wdata;
  logic              r_we, r_op_done, r_clr_pend;

  logic              w_idle, w_clr_go, w_host_go, w_putc_go, w_scroll_go, w_scroll_needed;
  logic              w_printable, w_is_lf, w_is_cr, w_bs_go, w_home, w_host_in_range;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [ADDR_W-1:0] w_cur_addr;

  // Arbitration: a latched clear beats host writes, which beat the character stream.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_clr_go    = w_idle & r_clr_pend;
  assign w_host_go   = w_idle & ~r_clr_pend & i_host_wr_valid;
  assign w_putc_go   = w_idle & ~r_clr_pend & ~i_host_wr_valid & i_putc_valid;

  assign w_printable = is_printable(i_putc_data);
  assign w_is_lf     = (i_putc_data == CH_LF);
  assign w_is_cr     = (i_putc_data == CH_CR);
  assign w_bs_go     = w_putc_go & (i_putc_data == CH_BS) & (w_col != '0);
  assign w_scroll_go = w_putc_go & w_scroll_needed;
  assign w_home      = (r_state == ST_CLEAR_ALL) & (r_idx == CELL_LAST);

  assign w_host_in_range = (32'(i_host_wr_addr) < NUM_CHARS);
  assign w_cur_addr      = ADDR_W'(NUM_COLS * 32'(w_row)) + ADDR_W'(w_col);

  assign o_host_wr_ready = w_host_go;
  assign o_putc_ready    = w_putc_go;
  assign o_busy          = ~w_idle | w_clr_go | w_scroll_go;
  assign o_buf_rd_addr   = r_rd_addr;
  assign o_buf_we        = r_we;
  assign o_buf_waddr     = r_waddr;
  assign o_buf_wdata     = r_wdata;
  assign o_op_done       = r_op_done;
  assign o_cursor_row    = w_row;
  assign o_cursor_col    = w_col;

  vgacon_cursor #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS),
    .ROW_W    (ROW_W),
    .COL_W    (COL_W)
  ) u_cursor (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_advance       (w_putc_go & w_printable),
    .i_newline       (w_putc_go & w_is_lf),
    .i_cr            (w_putc_go & w_is_cr),
    .i_back          (w_bs_go),
    .i_home          (w_home),
    .o_row           (w_row),
    .o_col           (w_col),
    .o_scroll_needed (w_scroll_needed)
  );

  // Pulses arriving while busy coalesce into one pending clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_clr_pend <= 1'b0;
    else if (w_clr_go) r_clr_pend <= 1'b0;
    else if (i_clr_req) r_clr_pend <= 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_target  <= ST_IDLE;
      r_idx     <= '0;
      r_rd_addr <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_op_done <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_op_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_clr_go) begin
            r_idx    <= '0;
            r_target <= ST_CLEAR_ALL;
            r_state  <= VBL_GATE ? ST_WAIT_VBL : ST_CLEAR_ALL;
          end else if (w_host_go) begin
            if (w_host_in_range) begin
              r_we    <= 1'b1;
              r_waddr <= i_host_wr_addr;
              r_wdata <= i_host_wr_data;
            end
          end else if (w_putc_go) begin
            if (w_printable) begin
              r_we    <= 1'b1;
              r_waddr <= w_cur_addr;
              r_wdata <= CELL_W'({i_putc_color, i_putc_data});
            end else if (w_bs_go) begin
              r_we    <= 1'b1;
              r_waddr <= w_cur_addr - ADDR_W'(1);
              r_wdata <= CELL_W'({i_putc_color, CH_SPACE});
            end
            if (w_scroll_go) begin
              r_idx     <= '0;
              r_rd_addr <= ADDR_W'(NUM_COLS);
              r_target  <= ST_SCROLL_COPY;
              r_state   <= VBL_GATE ? ST_WAIT_VBL : ST_SCROLL_COPY;
            end
          end
        end
        ST_WAIT_VBL: begin
          if (w_vblank) r_state <= r_target;
        end
        ST_SCROLL_COPY: begin
          r_we    <= 1'b1;
          r_waddr <= r_idx;
          r_wdata <= i_buf_rd_data;
          r_idx   <= r_idx + ADDR_W'(1);
          if (r_idx == COPY_LAST) r_state <= ST_SCROLL_CLEAR;
          else                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end
        ST_SCROLL_CLEAR, ST_CLEAR_ALL: begin
          r_we    <= 1'b1;
          r_waddr <= r_idx;
          r_wdata <= CELL_W'(BLANK_CELL);
          if (r_idx == CELL_LAST) begin
            r_idx     <= '0;
            r_op_done <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_idx <= r_idx + ADDR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
